// File: rtl/ttt_pkg.sv
// Shared constants for the tic-tac-toe sequencer: cell boundaries, winner codes,
// FSM encoding and the eight winning line masks.
package ttt_pkg;

  localparam logic [11:0] COL1_X = 12'd344;
  localparam logic [11:0] COL2_X = 12'd680;
  localparam logic [11:0] ROW1_Y = 12'd252;
  localparam logic [11:0] ROW2_Y = 12'd504;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit k of a board is cell k = row*3 + col.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'b001_010_100,  // anti-diagonal 2,4,6
    9'b100_010_001,  // diagonal 0,4,8
    9'b100_100_100,  // column 2
    9'b010_010_010,  // column 1
    9'b001_001_001,  // column 0
    9'b111_000_000,  // row 2
    9'b000_111_000,  // row 1
    9'b000_000_111   // row 0
  };

  function automatic logic has_line(input logic [8:0] board);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_LINES[i]) == WIN_LINES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cell_decode.sv
// Maps a cursor position to a board cell index; valid drops outside the active area.
module cell_decode
  import ttt_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [3:0]  cell_idx,
  output logic        valid
);

  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

  logic [1:0] col;
  logic [1:0] row;

  always_comb begin
    col = 2'd0;
    row = 2'd0;
    if (xpos >= COL2_X)      col = 2'd2;
    else if (xpos >= COL1_X) col = 2'd1;
    if (ypos >= ROW2_Y)      row = 2'd2;
    else if (ypos >= ROW1_Y) row = 2'd1;
  end

  assign cell_idx = ({2'b00, row} * 4'd3) + {2'b00, col};
  assign valid    = (xpos < H_LIM) && (ypos < V_LIM);

endmodule

// File: rtl/game_turn_ctrl.sv
// Tic-tac-toe sequencer: hover highlight, click-to-move, turn alternation and
// win/draw detection, all in the pclk domain.
module game_turn_ctrl
  import ttt_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        new_game,
  output logic [8:0]  square_hl,
  output logic [8:0]  board_x,
  output logic [8:0]  board_o,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over
);

  state_t     state;
  logic       ml_q;
  logic [3:0] cell_idx;
  logic       valid;
  logic [8:0] cell_mask;
  logic       cell_empty;
  logic       click;
  logic       accept;
  logic [8:0] mover_board;
  logic [8:0] hl_next;

  cell_decode #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_cell_decode (
    .xpos     (xpos),
    .ypos     (ypos),
    .cell_idx (cell_idx),
    .valid    (valid)
  );

  assign cell_mask   = 9'd1 << cell_idx;
  assign cell_empty  = ~|((board_x | board_o) & cell_mask);
  assign click       = mouse_left & ~ml_q;
  assign accept      = (state == ST_PLAY) & click & valid & cell_empty & ~new_game;
  assign mover_board = turn ? board_o : board_x;

  // The accepted cell becomes occupied on the same edge, so its highlight drops at once.
  always_comb begin
    hl_next = 9'd0;
    if ((state == ST_PLAY) && valid && cell_empty && !accept && !new_game)
      hl_next = cell_mask;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ST_PLAY;
      ml_q      <= 1'b0;
      square_hl <= 9'd0;
      board_x   <= 9'd0;
      board_o   <= 9'd0;
      turn      <= 1'b0;
      winner    <= WIN_NONE;
      game_over <= 1'b0;
    end else begin
      ml_q      <= mouse_left;
      square_hl <= hl_next;
      if (new_game) begin
        state     <= ST_PLAY;
        board_x   <= 9'd0;
        board_o   <= 9'd0;
        turn      <= 1'b0;
        winner    <= WIN_NONE;
        game_over <= 1'b0;
      end else begin
        case (state)
          ST_PLAY: begin
            if (accept) begin
              if (turn) board_o <= board_o | cell_mask;
              else      board_x <= board_x | cell_mask;
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            // A completed line outranks a full board, so a 9th-move win is a win.
            if (has_line(mover_board)) begin
              winner    <= turn ? WIN_O : WIN_X;
              game_over <= 1'b1;
              state     <= ST_DONE;
            end else if (&(board_x | board_o)) begin
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
              state     <= ST_DONE;
            end else begin
              turn  <= ~turn;
              state <= ST_PLAY;
            end
          end
          ST_DONE: ;
          default: state <= ST_PLAY;
        endcase
      end
    end
  end

endmodule
